// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared constants and state encoding for the FFT job sequencer
//
// Purpose : job geometry (word count, compute ops, total engine ops, word
//           stride), the ALU op code for FFT-load, and the controller state type.
// Ports   : none (package).
package fft_ctrl_pkg;

   localparam int N_WORDS     = 16;                    // 8 complex points, re/im interleaved
   localparam int CALC_OPS    = 6;                     // compute ops between load and export
   localparam int TOTAL_OPS   = 2 * N_WORDS + CALC_OPS; // ops the engine phase counter expects per job
   localparam int WORD_STRIDE = 4;                     // bytes per sample word
   localparam int WCNT_W      = $clog2(N_WORDS);

   // ALU op select value that routes operand 1 into the FFT engine.
   localparam logic [4:0] ALU_OP_FFT_LOAD = 5'h1c;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CALC,
      ST_EXPORT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/fft_job_ctrl_if.sv
// rtl/fft_job_ctrl_if.sv - memory and FFT-engine bus between the job controller and its neighbours
//
// Purpose : groups the data-memory read/write port and the ALU FFT-op path.
// Signals : mem_rd_en/mem_rd_addr/mem_rd_data  read port, 1-cycle latency
//           mem_wr_en/mem_wr_addr/mem_wr_data  write port
//           fft_op_en/fft_din/fft_dout         FFT op strobe, operand 1, registered result
// Modports: master = controller side, slave = memory/ALU side.
interface fft_job_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);

   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              fft_op_en;
   logic [DATA_W-1:0] fft_din;
   logic [DATA_W-1:0] fft_dout;

   modport master (
      output mem_rd_en, mem_rd_addr,
      input  mem_rd_data,
      output mem_wr_en, mem_wr_addr, mem_wr_data,
      output fft_op_en, fft_din,
      input  fft_dout
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr,
      output mem_rd_data,
      input  mem_wr_en, mem_wr_addr, mem_wr_data,
      input  fft_op_en, fft_din,
      output fft_dout
   );

endinterface

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - base register plus word counter producing a byte address
//
// Purpose : captures a byte base on load_i and walks N_WORDS words from it.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           load_i, base_i  capture base and clear the word index
//           step_i          advance to the next word
//           addr_o          base + stride*index, modulo 2^ADDR_W
//           last_o          index is on the final word of the block
module fft_addr_gen
   import fft_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] base_q, base_d;
   logic [WCNT_W-1:0] idx_q, idx_d;

   always_comb begin
      base_d = base_q;
      idx_d  = idx_q;
      if (load_i) begin
         base_d = base_i;
         idx_d  = '0;
      end else if (step_i) begin
         idx_d = idx_q + 1'b1;   // wraps to 0 after the last word
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         idx_q  <= idx_d;
      end
   end

   // Carry out of the top bit is dropped, so blocks near the top of the map wrap silently.
   assign addr_o = base_q + (ADDR_W'(idx_q) << $clog2(WORD_STRIDE));
   assign last_o = (idx_q == WCNT_W'(N_WORDS - 1));

endmodule

// File: rtl/fft_job_ctrl.sv
// rtl/fft_job_ctrl.sv - sequencer running one complete 8-point FFT job on the ALU FFT engine
//
// Purpose : on start, streams 16 words from src into the engine, issues the 6
//           compute ops, issues the 16 export ops and writes the results to dst.
//           Exactly 38 contiguous engine ops per job.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           start               job request, sampled only in IDLE
//           src_addr, dst_addr  byte bases, captured when start is accepted
//           busy, done          job in flight / one-cycle end-of-job pulse
//           bus (master)        memory read/write port and FFT op path
//           job_cnt, last_cycles  completed jobs / cycles of last job
//                                 (present only with FFT_JOB_PERF_EN defined)
module fft_job_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   output logic              busy,
   output logic              done,
   fft_job_ctrl_if.master    bus
`ifdef FFT_JOB_PERF_EN
   ,
   output logic [31:0]       job_cnt,
   output logic [7:0]        last_cycles
`endif
);

   state_e            state_q, state_d;
   logic [4:0]        opcnt_q, opcnt_d;   // CALC: op index; EXPORT: export ops issued so far
   logic              op_q, op_d;         // engine op strobe, one cycle behind its issue
   logic              ld_q, ld_d;         // the op now on the bus is a load (data from memory)
   logic              exp1_q, exp1_d;     // export issued one cycle ago (op on the bus)
   logic              exp2_q, exp2_d;     // export issued two cycles ago (result on fft_dout)
   logic              accept;
   logic              exp_issue;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic              rd_last, wr_last;

   fft_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .base_i (src_addr),
      .step_i (rd_en),
      .addr_o (rd_addr),
      .last_o (rd_last)
   );

   fft_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .base_i (dst_addr),
      .step_i (exp2_q),
      .addr_o (wr_addr),
      .last_o (wr_last)
   );

   // States mark when an op is *issued*; the op reaches the engine one cycle later,
   // which lines the load ops up with the 1-cycle memory read latency.
   always_comb begin
      state_d   = state_q;
      opcnt_d   = opcnt_q;
      accept    = 1'b0;
      exp_issue = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (rd_last) begin
               state_d = ST_CALC;
               opcnt_d = '0;
            end
         end
         ST_CALC: begin
            if (opcnt_q == 5'(CALC_OPS - 1)) begin
               state_d = ST_EXPORT;
               opcnt_d = '0;
            end else begin
               opcnt_d = opcnt_q + 5'd1;
            end
         end
         ST_EXPORT: begin
            // Issue 16 export ops, then stay until the trailing write-back drains.
            if (opcnt_q != 5'(N_WORDS)) begin
               exp_issue = 1'b1;
               opcnt_d   = opcnt_q + 5'd1;
            end
            if (exp2_q && wr_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rd_en  = (state_q == ST_LOAD);
   assign ld_d   = rd_en;
   assign op_d   = rd_en || (state_q == ST_CALC) || exp_issue;
   assign exp1_d = exp_issue;
   assign exp2_d = exp1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         opcnt_q <= '0;
         op_q    <= 1'b0;
         ld_q    <= 1'b0;
         exp1_q  <= 1'b0;
         exp2_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opcnt_q <= opcnt_d;
         op_q    <= op_d;
         ld_q    <= ld_d;
         exp1_q  <= exp1_d;
         exp2_q  <= exp2_d;
      end
   end

   assign busy = (state_q == ST_LOAD) || (state_q == ST_CALC) || (state_q == ST_EXPORT);
   assign done = (state_q == ST_DONE);

   // Data/address outputs are gated so nothing leaks out while idle or in reset.
   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_rd_addr = rd_en ? rd_addr : '0;
   assign bus.fft_op_en   = op_q;
   assign bus.fft_din     = ld_q ? bus.mem_rd_data : '0;
   assign bus.mem_wr_en   = exp2_q;
   assign bus.mem_wr_addr = exp2_q ? wr_addr : '0;
   assign bus.mem_wr_data = exp2_q ? bus.fft_dout : '0;

`ifdef FFT_JOB_PERF_EN
   logic [31:0] job_cnt_q, job_cnt_d;
   logic [7:0]  cyc_q, cyc_d;
   logic [7:0]  last_cycles_q, last_cycles_d;

   // cyc_q holds the cycle number relative to the accept edge, so it reads 41 in DONE.
   always_comb begin
      job_cnt_d     = job_cnt_q;
      cyc_d         = cyc_q;
      last_cycles_d = last_cycles_q;
      if (accept) begin
         cyc_d = 8'd1;
      end else if (state_q != ST_IDLE) begin
         cyc_d = cyc_q + 8'd1;
      end
      if (state_q == ST_DONE) begin
         job_cnt_d     = job_cnt_q + 32'd1;
         last_cycles_d = cyc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_cnt_q     <= '0;
         cyc_q         <= '0;
         last_cycles_q <= '0;
      end else begin
         job_cnt_q     <= job_cnt_d;
         cyc_q         <= cyc_d;
         last_cycles_q <= last_cycles_d;
      end
   end

   assign job_cnt     = job_cnt_q;
   assign last_cycles = last_cycles_q;
`endif

endmodule

// File: tb/tb_fft_job_ctrl.sv
// tb/tb_fft_job_ctrl.sv - self-checking bench for fft_job_ctrl with memory and FFT engine models
module tb_fft_job_ctrl;
    import fft_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic        busy, done;
`ifdef FFT_JOB_PERF_EN
    logic [31:0] job_cnt;
    logic [7:0]  last_cycles;
`endif

    fft_job_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    fft_job_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
`ifdef FFT_JOB_PERF_EN
        ,
        .job_cnt     (job_cnt),
        .last_cycles (last_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input bit ok);
        n_chk++;
        if (ok) n_pass++;
        else $error("FAIL %s", tag);
    endtask

    function automatic logic [31:0] dft_word(input int k, input logic [31:0] x [16]);
        real acc, th;
        int  p;
        p   = k / 2;
        acc = 0.0;
        for (int n = 0; n < 8; n++) begin
            th = 2.0 * 3.14159265358979 * real'(p * n) / 8.0;
            if (k % 2 == 0)
                acc += real'($signed(x[2*n])) * $cos(th) + real'($signed(x[2*n+1])) * $sin(th);
            else
                acc += real'($signed(x[2*n+1])) * $cos(th) - real'($signed(x[2*n])) * $sin(th);
        end
        return 32'($rtoi(acc >= 0.0 ? acc + 0.5 : acc - 0.5));
    endfunction

    logic [31:0] mem [1024];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[11:2]];
        if (bus.mem_wr_en) mem[bus.mem_wr_addr[11:2]] <= bus.mem_wr_data;
    end

    int          ph;
    logic [31:0] ebuf [16];
    logic [31:0] eng_dout;
    assign bus.fft_dout = eng_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0;
        end else if (bus.fft_op_en) begin
            if (ph < N_WORDS) ebuf[ph] <= bus.fft_din;
            if (ph >= N_WORDS + CALC_OPS) eng_dout <= dft_word(ph - (N_WORDS + CALC_OPS), ebuf);
            ph <= (ph == TOTAL_OPS - 1) ? 0 : ph + 1;
        end
    end

    int          e = 0;
    int          acc_q[$], rd_cyc_q[$], op_q[$], wr_cyc_q[$], done_q[$];
    logic [31:0] rd_addr_q[$], wr_addr_q[$];

    always @(posedge clk) begin
        e <= e + 1;
        if (rst_n) begin
            if (start && !busy && !done) acc_q.push_back(e);
            if (bus.mem_rd_en) begin
                rd_cyc_q.push_back(e);
                rd_addr_q.push_back(bus.mem_rd_addr);
            end
            if (bus.fft_op_en) op_q.push_back(e);
            if (bus.mem_wr_en) begin
                wr_cyc_q.push_back(e);
                wr_addr_q.push_back(bus.mem_wr_addr);
            end
            if (done) done_q.push_back(e);
        end
    end

    logic [31:0] src_img [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] base, input int kind);
        logic [31:0] a, v;
        for (int i = 0; i < N_WORDS; i++) begin
            case (kind)
                0:       v = (i == 0) ? 32'd1 : 32'd0;
                1:       v = (i % 2 == 0) ? 32'd1 : 32'd0;
                default: v = $urandom_range(0, 200) - 100;
            endcase
            src_img[i] = v;
            a          = base + 32'(4 * i);
            bd_idx     = a[11:2];
            bd_data    = v;
            bd_we      = 1'b1;
            tick();
        end
        bd_we = 1'b0;
    endtask

    task automatic clear_logs();
        acc_q.delete(); rd_cyc_q.delete(); op_q.delete(); wr_cyc_q.delete();
        done_q.delete(); rd_addr_q.delete(); wr_addr_q.delete();
    endtask

    task automatic start_job(input logic [31:0] src, input logic [31:0] dst);
        clear_logs();
        src_addr = src;
        dst_addr = dst;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("busy_after_accept", busy === 1'b1);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int c = 0; c < 200 && at < 0; c++) begin
            if (done) at = e;
            else tick();
        end
    endtask

    task automatic check_job(input logic [31:0] src, input logic [31:0] dst, input int done_at);
        int          t0;
        logic [31:0] a;
        chk("accepts", acc_q.size() === 1);
        t0 = (acc_q.size() > 0) ? acc_q[0] : 0;
        chk("done_cycle", (done_at - t0) === 41);
        chk("rd_count", rd_cyc_q.size() === N_WORDS);
        for (int i = 0; i < N_WORDS; i++) begin
            a = src + 32'(4 * i);
            chk("rd_cycle", (rd_cyc_q[i] - t0) === (i + 1));
            chk("rd_addr", rd_addr_q[i] === a);
        end
        chk("op_count", op_q.size() === TOTAL_OPS);
        chk("op_first", (op_q[0] - t0) === 2);
        chk("op_last", (op_q[$] - t0) === 39);
        chk("wr_count", wr_cyc_q.size() === N_WORDS);
        for (int k = 0; k < N_WORDS; k++) begin
            a = dst + 32'(4 * k);
            chk("wr_cycle", (wr_cyc_q[k] - t0) === (25 + k));
            chk("wr_addr", wr_addr_q[k] === a);
            chk("result", mem[a[11:2]] === dft_word(k, src_img));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int          at;
        logic [31:0] a;

        repeat (3) tick();
        chk("rst_busy", busy === 1'b0);
        chk("rst_done", done === 1'b0);
        chk("rst_rd_en", bus.mem_rd_en === 1'b0);
        chk("rst_rd_addr", bus.mem_rd_addr === 32'h0);
        chk("rst_wr_en", bus.mem_wr_en === 1'b0);
        chk("rst_wr_addr", bus.mem_wr_addr === 32'h0);
        chk("rst_wr_data", bus.mem_wr_data === 32'h0);
        chk("rst_op_en", bus.fft_op_en === 1'b0);
        chk("rst_fft_din", bus.fft_din === 32'h0);
`ifdef FFT_JOB_PERF_EN
        chk("rst_job_cnt", job_cnt === 32'd0);
        chk("rst_last_cycles", last_cycles === 8'd0);
`endif
        rst_n = 1'b1;
        tick();

        preload(32'h100, 0);
        start_job(32'h100, 32'h200);
        wait_done(at);
        chk("busy_in_done", busy === 1'b0);
        chk("op_en_in_done", bus.fft_op_en === 1'b0);
        check_job(32'h100, 32'h200, at);
        for (int k = 0; k < N_WORDS; k++) begin
            a = 32'h200 + 32'(4 * k);
            chk("impulse_const", mem[a[11:2]] === ((k % 2 == 0) ? 32'd1 : 32'd0));
        end
        tick();
`ifdef FFT_JOB_PERF_EN
        chk("job_cnt_1", job_cnt === 32'd1);
        chk("last_cycles_1", last_cycles === 8'd41);
`endif

        preload(32'h100, 1);
        start_job(32'h100, 32'h300);
        wait_done(at);
        check_job(32'h100, 32'h300, at);
        for (int k = 0; k < N_WORDS; k++) begin
            a = 32'h300 + 32'(4 * k);
            chk("dc_const", mem[a[11:2]] === ((k == 0) ? 32'd8 : 32'd0));
        end
        tick();

        preload(32'h100, 2);
        start_job(32'h100, 32'h400);
        wait_done(at);
        check_job(32'h100, 32'h400, at);
        tick();
        start_job(32'h100, 32'h500);
        wait_done(at);
        check_job(32'h100, 32'h500, at);
        tick();
        preload(32'h180, 2);
        start_job(32'h180, 32'h500);
        wait_done(at);
        check_job(32'h180, 32'h500, at);
        tick();

        preload(32'h100, 2);
        clear_logs();
        src_addr = 32'h100;
        dst_addr = 32'h400;
        start    = 1'b1;
        tick();
        src_addr = 32'h0a00;
        dst_addr = 32'h0b00;
        wait_done(at);
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_job(32'h100, 32'h400, at);
        chk("held_done_pulses", done_q.size() === 1);
        chk("held_idle_busy", busy === 1'b0);

        preload(32'hffff_fff0, 2);
        start_job(32'hffff_fff0, 32'hffff_fff0);
        wait_done(at);
        check_job(32'hffff_fff0, 32'hffff_fff0, at);
        chk("wrap_rd4", rd_addr_q[4] === 32'h0);
        chk("wrap_rd15", rd_addr_q[15] === 32'h2c);
        tick();

        preload(32'h100, 2);
        start_job(32'h100, 32'h600);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy === 1'b0);
        chk("midrst_rd_en", bus.mem_rd_en === 1'b0);
        chk("midrst_rd_addr", bus.mem_rd_addr === 32'h0);
        chk("midrst_op_en", bus.fft_op_en === 1'b0);
        chk("midrst_fft_din", bus.fft_din === 32'h0);
        chk("midrst_wr_en", bus.mem_wr_en === 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        chk("midrst_no_writes", wr_cyc_q.size() === 0);
        chk("midrst_no_done", done_q.size() === 0);
        chk("midrst_idle", busy === 1'b0);
`ifdef FFT_JOB_PERF_EN
        chk("midrst_job_cnt", job_cnt === 32'd0);
`endif

        preload(32'h100, 2);
        start_job(32'h100, 32'h700);
        wait_done(at);
        check_job(32'h100, 32'h700, at);
        tick();
`ifdef FFT_JOB_PERF_EN
        chk("job_cnt_end", job_cnt === 32'd1);
        chk("last_cycles_end", last_cycles === 8'd41);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_job_ctrl.md
Name: fft_job_ctrl

Overview:
- Sequencer that runs one complete 8-point FFT job on the ALU-embedded FFT engine without software issuing every FFT-load instruction.
- On start, it streams 16 words (interleaved re/im) from data memory into the engine and issues the 6 compute ops.
- It then issues the 16 export ops and writes the 16 results back to memory.
- Sits beside the ALU. When busy, it owns the ALU's FFT-op select and operand-1 path.

Parameters:
- DATA_W, 32, sample word width (signed)
- ADDR_W, 32, byte address width
- N_WORDS, 16, words loaded/exported per job (8 complex points)
- CALC_OPS, 6, compute ops between load and export

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- src_addr  in  ADDR_W  byte base of input block; captured on start
- dst_addr  in  ADDR_W  byte base of output block; captured on start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at job end
- mem_rd_en  out  1  read strobe; fixed 1-cycle read latency
- mem_rd_addr  out  ADDR_W  read byte address
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  write byte address
- mem_wr_data  out  DATA_W  write data
- fft_op_en  out  1  forces the ALU op to FFT-load for this cycle
- fft_din  out  DATA_W  drives ALU operand 1 during FFT ops
- fft_dout  in  DATA_W  ALU result, registered one cycle after the op

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- The engine has no reset. Its internal phase counter must see exactly 38 ops per job (16 load + 6 calc + 16 export). The controller never issues a partial job.
- States and transitions:
  - IDLE: start=1 captures addresses and moves to LOAD. start while busy is ignored.
  - LOAD (16 cycles): mem_rd_en=1, mem_rd_addr=src+4*i for i=0..15.
    - One cycle later: fft_op_en=1, fft_din=mem_rd_data. This 1-cycle skew overlaps into the first CALC cycle.
    - Load order: x0re, x0im, …, x7im in natural order. The engine bit-reverses internally.
  - CALC (6 cycles): fft_op_en=1, fft_din=0.
  - EXPORT (16 cycles): fft_op_en=1.
    - One cycle later: mem_wr_en=1, mem_wr_addr=dst+4*k, mem_wr_data=fft_dout, for k=0..15 (X0re, X0im, …, X7im).
  - DONE (1 cycle): done=1, busy=0, then IDLE. A start in the DONE cycle is ignored.
- Timing from start sampled at cycle 0:
  - reads: cycles 1–16
  - ops: cycles 2–39, contiguous
  - writes: cycles 25–40
  - done: cycle 41
- Addresses are computed modulo 2^ADDR_W; wrap-around is silent.
- src/dst regions may overlap. All reads complete (cycle 16) before the first write (cycle 25).
- No backpressure: memory must accept one access per cycle.
- Reset mid-job returns to IDLE immediately and desynchronises the engine. System reset must reset both; this controller does not attempt recovery.
- fft_op_en is never high in IDLE or DONE.

Optional Feature:
- Macro FFT_JOB_PERF_EN.
- Defined: adds outputs job_cnt[31:0] (completed jobs, incremented on done, wraps) and last_cycles[7:0] (cycles from start accept to done of the last job; always 41 in this design, used by the bench as a self-check). Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fft_ctrl_pkg:
  - state encoding (IDLE, LOAD, CALC, EXPORT, DONE)
  - N_WORDS, CALC_OPS, total ops 38, word stride 4
  - the FFT-load ALU op code constant
- One natural sub-module, fft_addr_gen: base register plus word counter producing a byte address and last-word flag. Instantiated twice (read, write).

Test Plan:
- Impulse: src holds x0re=1, all else 0; start -> dst holds re=1, im=0 for all 8 points; done exactly 41 cycles after start.
- DC: all re=1, im=0 -> X0re=8; the other 15 words 0.
- Back-to-back: two jobs with different data, second start issued the cycle after done -> both correct; the second job proves the engine phase resynchronises (38 fft_op_en per job, counted).
- start held high while busy, and asserted in the DONE cycle -> only one job runs; addresses captured at first accept.
- Wrap: src=0xFFFF_FFF0 -> reads 0xFFFF_FFF0, …, 0xFFFF_FFFC, 0x0000_0000, …, 0x0000_002C. dst=src (in-place) -> correct results.
- Reset asserted mid-LOAD (cycle 5) -> all outputs 0 asynchronously, state IDLE, no writes issued.
